// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the M-extension execute-stage sequencer:
// funct3 encodings, FSM state encoding and the default datapath width.
package muldiv_sequencer_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // DIV and REM are the signed divide ops (funct3[0] clear).
    function automatic logic div_is_signed(input logic [2:0] f3);
        return ~f3[0];
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
// Ports: rem/quo/dvs in (quo shifts the dividend out MSB-first), rem_next/quo_next out.
module muldiv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // One extra bit so the trial subtraction's sign is visible.
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_comb begin
        rem_next = shifted[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M execute-stage sequencer: 1-cycle registered multiply, XLEN-step
// restoring divide with special-case shortcuts; busy stalls, done qualifies result.
// Ports: clk, rst (async high), start_e, funct3_e, src_a_e, src_b_e, flush_e
//        in; busy, done, result out.
// Optional: define MULDIV_EARLY_OUT_EN to finish |a|<|b| divides at accept.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_e,
    input  logic [2:0]      funct3_e,
    input  logic [XLEN-1:0] src_a_e,
    input  logic [XLEN-1:0] src_b_e,
    input  logic            flush_e,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

    state_t state;
    state_t state_n;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvs_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic [XLEN-1:0]  final_q;
    logic [XLEN-1:0]  result_q;

    // Accept-time decode
    logic            accept;
    logic            sgn_a_in;
    logic            sgn_b_in;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div0;
    logic            ovf;
    logic            early;
    logic            special;
    logic [XLEN-1:0] spec_val;

    assign accept   = (state == ST_IDLE) & start_e & ~flush_e;
    assign sgn_a_in = div_is_signed(funct3_e) & src_a_e[XLEN-1];
    assign sgn_b_in = div_is_signed(funct3_e) & src_b_e[XLEN-1];
    assign mag_a    = sgn_a_in ? -src_a_e : src_a_e;
    assign mag_b    = sgn_b_in ? -src_b_e : src_b_e;
    assign div0     = (src_b_e == '0);
    assign ovf      = div_is_signed(funct3_e)
                    & (src_a_e == MIN_NEG)
                    & (&src_b_e);

`ifdef MULDIV_EARLY_OUT_EN
    assign early = ~div0 & (mag_a < mag_b);
`else
    assign early = 1'b0;
`endif

    assign special = div0 | ovf | early;

    // funct3[1] selects remainder over quotient.
    always_comb begin
        spec_val = '0;
        unique case (1'b1)
            div0:    spec_val = funct3_e[1] ? src_a_e : '1;
            ovf:     spec_val = funct3_e[1] ? '0 : MIN_NEG;
            default: spec_val = funct3_e[1] ? src_a_e : '0;
        endcase
    end

    // Divider iteration and sign fixup
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] div_res;
    logic            div_last;

    muldiv_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .dvs      (dvs_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign q_fix    = (sign_a_q ^ sign_b_q) ? -step_quo : step_quo;
    assign r_fix    = sign_a_q ? -step_rem : step_rem;
    assign div_res  = f3_q[1] ? r_fix : q_fix;
    assign div_last = (cnt == CNT_LAST);

    // Multiplier: operands extended by one bit so MULHSU/MULHU fit a
    // single signed multiply.
    logic                   ext_a;
    logic                   ext_b;
    logic signed [2*XLEN+1:0] prod;
    logic [XLEN-1:0]        mul_res;
    logic                   unused_prod;

    assign ext_a = (f3_q != F3_MULHU) & a_q[XLEN-1];
    assign ext_b = (f3_q == F3_MULH) & b_q[XLEN-1];
    assign prod  = $signed({ext_a, a_q}) * $signed({ext_b, b_q});
    assign mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0]
                                      : prod[2*XLEN-1:XLEN];
    assign unused_prod = ^prod[2*XLEN+1:2*XLEN];

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    busy = 1'b1;
                    if (!funct3_e[2]) state_n = ST_MUL;
                    else if (special) state_n = ST_DONE;
                    else              state_n = ST_DIV;
                end
            end
            ST_MUL: begin
                busy    = 1'b1;
                state_n = ST_DONE;
            end
            ST_DIV: begin
                busy = 1'b1;
                if (div_last) state_n = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (flush_e) begin
            state_n = ST_IDLE;
            busy    = 1'b0;
            done    = 1'b0;
        end
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            final_q  <= '0;
            result_q <= '0;
        end else if (!flush_e) begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        f3_q     <= funct3_e;
                        a_q      <= src_a_e;
                        b_q      <= src_b_e;
                        sign_a_q <= sgn_a_in;
                        sign_b_q <= sgn_b_in;
                        quo_q    <= mag_a;
                        dvs_q    <= mag_b;
                        rem_q    <= '0;
                        cnt      <= '0;
                        final_q  <= spec_val;
                    end
                end
                ST_MUL: final_q <= mul_res;
                ST_DIV: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt   <= div_last ? '0 : cnt + 1'b1;
                    if (div_last) final_q <= div_res;
                end
                ST_DONE: result_q <= final_q;
                default: ;
            endcase
        end
    end

    // A flushed DONE cycle keeps showing the previous completion.
    assign result = (state == ST_DONE && !flush_e) ? final_q : result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed plus random M-ops
// checked for result value and completion cycle against a reference model.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_e;
    logic [2:0]      funct3_e;
    logic [XLEN-1:0] src_a_e;
    logic [XLEN-1:0] src_b_e;
    logic            flush_e;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    muldiv_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_e  (start_e),
        .funct3_e (funct3_e),
        .src_a_e  (src_a_e),
        .src_b_e  (src_b_e),
        .flush_e  (flush_e),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] val;
        int          at;
        logic [2:0]  f3;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    // Reference model: plain arithmetic on the RV32M definitions.
    function automatic logic [31:0] ref_res(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ua, ub, r;
        logic [63:0] pu;
        logic [63:0] pr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (f3)
            3'd0: begin pr = 64'(sa * sb); return pr[31:0]; end
            3'd1: begin pr = 64'(sa * sb); return pr[63:32]; end
            3'd2: begin pr = 64'(sa * ub); return pr[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = sa / sb; return r[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                r = ua / ub; return r[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                r = sa % sb; return r[31:0];
            end
            default: begin
                if (b == 0) return a;
                r = ua % ub; return r[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        longint ma, mb;
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        ma = f3[0] ? longint'(a) : longint'($signed(a));
        mb = f3[0] ? longint'(b) : longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef MULDIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        #1;
        if (!rst && done) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cycle=%0d result=%h", cyc, result);
            end else begin
                mon_e = sbq.pop_front();
                if (result !== mon_e.val || cyc != mon_e.at) begin
                    errors++;
                    $display("FAIL op_f3_%0d got result=%h cycle=%0d want result=%h cycle=%0d",
                             mon_e.f3, result, cyc, mon_e.val, mon_e.at);
                end
            end
        end
    end

    // Driven at a negedge; if the DUT is in DONE the op is accepted next cycle.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit expect_done,
                         output int c0);
        exp_t x;
        bit   was_done;
        was_done = done;
        c0 = was_done ? cyc + 1 : cyc;
        start_e  = 1'b1;
        funct3_e = f3;
        src_a_e  = a;
        src_b_e  = b;
        if (expect_done) begin
            x.val = ref_res(f3, a, b);
            x.at  = c0 + ref_lat(f3, a, b);
            x.f3  = f3;
            sbq.push_back(x);
        end
        if (!was_done) begin
            #1;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL accept_busy got=%b want=1", busy);
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout cycle=%0d", cyc);
        end
    endtask

    task automatic expect_idle(input string name, input bit chk_result);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || (chk_result && result !== '0)) begin
            errors++;
            $display("FAIL %s got busy=%b done=%b result=%h want 0/0/0",
                     name, busy, done, result);
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    op_t dir[] = '{
        '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD},
        '{3'd1, 32'h0000_0007, 32'hFFFF_FFFD},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002},
        '{3'd4, 32'hFFFF_FFEC, 32'h0000_0003},
        '{3'd6, 32'hFFFF_FFEC, 32'h0000_0003},
        '{3'd5, 32'd100,       32'd7},
        '{3'd7, 32'd100,       32'd7},
        '{3'd5, 32'd5,         32'd0},
        '{3'd6, 32'd5,         32'd0},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF},
        '{3'd5, 32'd3,         32'd9},
        '{3'd6, 32'hFFFF_FFFD, 32'd9}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst      = 1'b1;
        start_e  = 1'b0;
        flush_e  = 1'b0;
        funct3_e = '0;
        src_a_e  = '0;
        src_b_e  = '0;
        @(negedge clk);
        @(negedge clk);
        expect_idle("reset_state", 1'b1);
        rst = 1'b0;
        @(negedge clk);

        foreach (dir[i]) begin
            issue(dir[i].f3, dir[i].a, dir[i].b, 1'b1, c0);
            wait_done();
        end
        start_e = 1'b0;
        repeat (2) @(negedge clk);

        // Flush mid-divide, then a multiply right behind it.
        issue(3'd4, 32'd1000, 32'd10, 1'b0, c0);
        repeat (10) @(negedge clk);
        start_e = 1'b0;
        flush_e = 1'b1;
        #1;
        expect_idle("flush_busy", 1'b0);
        @(negedge clk);
        flush_e = 1'b0;
        checks++;
        if (cyc != c0 + 11) begin
            errors++;
            $display("FAIL flush_timing got=%0d want=%0d", cyc, c0 + 11);
        end
        issue(3'd0, 32'd2, 32'd3, 1'b1, c0);
        wait_done();
        start_e = 1'b0;
        @(negedge clk);

        // start and flush together: must not accept.
        issue(3'd4, 32'd50, 32'd7, 1'b0, c0);
        flush_e = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_flush_busy got=%b want=0", busy);
        end
        @(negedge clk);
        start_e = 1'b0;
        flush_e = 1'b0;
        #1;
        expect_idle("start_flush_noaccept", 1'b0);

        // Reset in the middle of a divide.
        @(negedge clk);
        issue(3'd4, 32'd1000, 32'd7, 1'b0, c0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        start_e = 1'b0;
        #1;
        expect_idle("reset_midop", 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_idle("after_reset", 1'b1);

        // Random back-to-back traffic.
        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 1'b1, c0);
            wait_done();
        end
        start_e = 1'b0;
        repeat (3) @(negedge clk);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
